rl_ram_1r1w_generic: RTL and testbench

RL_RAM_1R1W_GENERIC -- requirements
Module: rl_ram_1r1w_generic

---
 rtl/rl_ram_1r1w_generic.sv | 91 +++++++++
 tb/tb_rl_ram_1r1w_generic.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rl_ram_1r1w_generic.sv
// rl_ram_1r1w_generic
// Generic 1-read / 1-write synchronous RAM with byte-lane write enables.
// The storage array is written and read in a single clocked process with no
// reset so it maps onto block RAM. Same-address read/write collisions are
// resolved write-first per lane by a registered compare-and-mux that sits
// outside the array.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rst_ni   : asynchronous reset, ACTIVE-HIGH (name kept for compatibility)
//   we_i     : write enable
//   waddr_i  : word write address
//   be_i     : byte-lane write enables, lane k covers bits [8k+7:8k]
//   din_i    : write data
//   raddr_i  : word read address, read every cycle
//   dout_o   : read data, one cycle after raddr_i
module rl_ram_1r1w_generic #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  localparam int NB   = (DBITS + 7) / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [NB-1:0]    be_i,
  input  logic [DBITS-1:0] din_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [DBITS-1:0] dout_o
);

  localparam int DEPTH = 2 ** ABITS;

  // Contents are intentionally left uninitialized.
  logic [DBITS-1:0] mem [DEPTH];

  logic [DBITS-1:0] lane_mask;
  logic [DBITS-1:0] wr_mask;
  logic             wr_en;
  logic             byp_hit;

  logic [DBITS-1:0] rd_data_q;
  logic [DBITS-1:0] byp_mask_d, byp_mask_q;
  logic [DBITS-1:0] byp_data_d, byp_data_q;
  logic             rd_valid_d, rd_valid_q;

  // Expand lane enables to a per-bit mask; the top lane is naturally clipped
  // because the mask is only DBITS wide.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < DBITS; i++) begin
      lane_mask[i] = be_i[i / 8];
    end
    // Writes are blocked while reset is asserted so memory survives reset.
    wr_en      = we_i & ~rst_ni;
    wr_mask    = wr_en ? lane_mask : '0;
    byp_hit    = wr_en & (raddr_i == waddr_i);
    byp_mask_d = byp_hit ? lane_mask : '0;
    byp_data_d = din_i;
    rd_valid_d = 1'b1;
  end

  // Array port: byte-enabled write plus synchronous read of the old contents.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DBITS; i++) begin
      if (wr_mask[i]) begin
        mem[waddr_i][i] <= din_i[i];
      end
    end
    rd_data_q <= mem[raddr_i];
  end

  // Bypass and output-valid registers. rd_valid_q forces dout_o to zero
  // asynchronously during reset without touching the array read register.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      rd_valid_q <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Mux of registers only: no path from any input to dout_o.
  assign dout_o = rd_valid_q ? ((rd_data_q & ~byp_mask_q) | (byp_data_q & byp_mask_q))
                             : '0;

endmodule

// File: tb/tb_rl_ram_1r1w_generic.sv
module tb_rl_ram_1r1w_generic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [9:0]  waddr = '0;
  logic [3:0]  be = '0;
  logic [31:0] din = '0;
  logic [9:0]  raddr = '0;
  logic [31:0] dout;

  logic        we2 = 1'b0;
  logic [3:0]  waddr2 = '0;
  logic [1:0]  be2 = '0;
  logic [11:0] din2 = '0;
  logic [3:0]  raddr2 = '0;
  logic [11:0] dout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rl_ram_1r1w_generic #(.ABITS(10), .DBITS(32)) dut (
    .clk_i(clk), .rst_ni(rst), .we_i(we), .waddr_i(waddr), .be_i(be),
    .din_i(din), .raddr_i(raddr), .dout_o(dout)
  );

  rl_ram_1r1w_generic #(.ABITS(4), .DBITS(12)) dut12 (
    .clk_i(clk), .rst_ni(rst), .we_i(we2), .waddr_i(waddr2), .be_i(be2),
    .din_i(din2), .raddr_i(raddr2), .dout_o(dout2)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [9:0]  waddr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [9:0]  raddr;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic w, input logic [9:0] wa, input logic [3:0] b,
                     input logic [31:0] d, input logic [9:0] ra, input logic c,
                     input logic [31:0] e);
    vec_t v;
    v.name = n; v.we = w; v.waddr = wa; v.be = b; v.din = d; v.raddr = ra; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add("full_wr",      1, 5,    4'hF, 32'hDEADBEEF, 0, 0, 0);
    add("full_rd",      0, 0,    4'h0, 32'h0,        5, 1, 32'hDEADBEEF);
    add("be0011_wr",    1, 5,    4'h3, 32'h11223344, 6, 0, 0);
    add("be0011_rd",    0, 0,    4'h0, 32'h0,        5, 1, 32'hDEAD3344);
    add("be0001_wr",    1, 5,    4'h1, 32'h000000AA, 9, 0, 0);
    add("be0001_rd",    0, 0,    4'h0, 32'h0,        5, 1, 32'hDEAD33AA);
    add("coll_init",    1, 7,    4'hF, 32'hCAFEF00D, 0, 0, 0);
    add("coll_same",    1, 7,    4'h5, 32'h12345678, 7, 1, 32'hCA34F078);
    add("coll_after",   0, 0,    4'h0, 32'h0,        7, 1, 32'hCA34F078);
    add("nowr_be0",     1, 5,    4'h0, 32'hFFFFFFFF, 5, 1, 32'hDEAD33AA);
    add("nowr_we0",     0, 5,    4'hF, 32'hFFFFFFFF, 5, 1, 32'hDEAD33AA);
    add("nowr_after",   0, 0,    4'h0, 32'h0,        5, 1, 32'hDEAD33AA);
    add("bnd_wr0",      1, 0,    4'hF, 32'h00000001, 9, 0, 0);
    add("bnd_wr1023",   1, 1023, 4'hF, 32'h00000002, 0, 1, 32'h00000001);
    add("bnd_rd1023",   0, 0,    4'h0, 32'h0,     1023, 1, 32'h00000002);
    add("bnd_rd0",      0, 0,    4'h0, 32'h0,        0, 1, 32'h00000001);
    add("diff_old",     1, 5,    4'hF, 32'h55555555, 7, 1, 32'hCA34F078);
    add("diff_vis",     1, 7,    4'hF, 32'h00000000, 5, 1, 32'h55555555);
    add("diff_rd7",     0, 0,    4'h0, 32'h0,        7, 1, 32'h00000000);

    // Reset state, with a write attempted during reset.
    we = 1; waddr = 3; be = 4'hF; din = 32'h0BADF00D; raddr = 3;
    #1;
    check("reset_dout", dout, 32'h0);
    step();
    check("reset_hold", dout, 32'h0);
    step();
    rst = 0; we = 0;
    step();
    // First read after release; array content is unknown, just confirm it
    // is not the data attempted during reset (write was blocked).
    checks++;
    if (dout === 32'h0BADF00D) begin
      errors++;
      $display("FAIL reset_wr_block: got 0x%08h expected not 0x0badf00d", dout);
    end

    foreach (vecs[i]) begin
      we = vecs[i].we; waddr = vecs[i].waddr; be = vecs[i].be;
      din = vecs[i].din; raddr = vecs[i].raddr;
      step();
      if (vecs[i].chk) check(vecs[i].name, dout, vecs[i].exp);
    end

    // Async reset mid-cycle, memory retention and write blocking.
    we = 1; waddr = 5; be = 4'hF; din = 32'hDEADBEEF; raddr = 0;
    step();
    we = 0; raddr = 5;
    step();
    check("pre_reset", dout, 32'hDEADBEEF);
    #3 rst = 1;
    #1 check("async_clear", dout, 32'h0);
    we = 1; waddr = 5; be = 4'hF; din = 32'h0;
    step();
    check("reset_ignore_rd", dout, 32'h0);
    step();
    rst = 0; we = 0; raddr = 5;
    step();
    check("post_reset_rd", dout, 32'hDEADBEEF);

    // Odd width: DBITS=12, top lane is bits [11:8].
    we2 = 1; waddr2 = 3; be2 = 2'b11; din2 = 12'hABC; raddr2 = 0;
    step();
    we2 = 0; raddr2 = 3;
    step();
    check("w12_full", {20'h0, dout2}, 32'h00000ABC);
    we2 = 1; be2 = 2'b10; din2 = 12'h5DE; raddr2 = 4;
    step();
    we2 = 0; raddr2 = 3;
    step();
    check("w12_top_lane", {20'h0, dout2}, 32'h000005BC);
    we2 = 1; be2 = 2'b01; din2 = 12'h0FF; raddr2 = 3;
    step();
    check("w12_coll_low", {20'h0, dout2}, 32'h000005FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
